// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage: word width, FSM encoding,
// write-back select encoding and the MEM/WB register payload.
package mem_stage_pkg;

    localparam int WORD_W = 16;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_BUSY = 1'b1
    } ms_state_t;

    localparam logic WB_SEL_MEM = 1'b0;
    localparam logic WB_SEL_ALU = 1'b1;

    typedef struct packed {
        logic              valid;
        logic              mem_to_reg;
        logic              reg_write;
        logic              halt;
        logic [2:0]        write_reg;
        logic [WORD_W-1:0] alu_result;
        logic [WORD_W-1:0] read_data;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears the entry so write-back sees
// no valid instruction, no register write and no halt.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load_bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores over a req/done handshake, stalls upstream
// while an access is outstanding, and guards against a hung memory.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] alu_result,
    input  logic [WORD_W-1:0] store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [2:0]        write_reg,
    input  logic              halt,
    output logic              stall_out,
    output logic              dm_req,
    output logic              dm_wr,
    output logic [WORD_W-1:0] dm_addr,
    output logic [WORD_W-1:0] dm_wdata,
    input  logic              dm_done,
    input  logic [WORD_W-1:0] dm_rdata,
    output logic              wb_valid,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic              wb_halt,
    output logic [2:0]        wb_write_reg,
    output logic [WORD_W-1:0] wb_alu_result,
    output logic [WORD_W-1:0] wb_read_data,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    ms_state_t         state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [WORD_W-1:0] cap_addr;
    logic [WORD_W-1:0] cap_wdata;
    logic              cap_wr;
    logic              cap_mem_to_reg;
    logic              cap_reg_write;
    logic [2:0]        cap_write_reg;
    logic              cap_halt;

    logic    is_mem_op;
    logic    misaligned;
    logic    timeout;
    logic    load_bubble;
    mem_wb_t wb_d;
    mem_wb_t wb_q;

    assign is_mem_op  = in_valid & (mem_read | mem_write);
    assign misaligned = alu_result[0];
    // The last permitted BUSY cycle; a done arriving here still wins.
    assign timeout    = (state == MS_BUSY) && !dm_done && (wait_cnt == LAST_WAIT);

    always_comb begin
        stall_out   = 1'b0;
        dm_req      = 1'b0;
        dm_wr       = 1'b0;
        dm_addr     = '0;
        dm_wdata    = '0;
        load_bubble = 1'b0;
        wb_d        = '0;
        if (!rst) begin
            case (state)
                MS_IDLE: begin
                    if (is_mem_op && !misaligned) begin
                        dm_req      = 1'b1;
                        dm_wr       = mem_write;
                        dm_addr     = alu_result;
                        dm_wdata    = store_data;
                        stall_out   = 1'b1;
                        load_bubble = 1'b1;
                    end else if (is_mem_op) begin
                        load_bubble = 1'b1;
                    end else begin
                        wb_d.valid      = in_valid;
                        wb_d.mem_to_reg = mem_to_reg;
                        wb_d.reg_write  = reg_write;
                        wb_d.halt       = halt;
                        wb_d.write_reg  = write_reg;
                        wb_d.alu_result = alu_result;
                        wb_d.read_data  = '0;
                    end
                end
                MS_BUSY: begin
                    dm_req   = 1'b1;
                    dm_wr    = cap_wr;
                    dm_addr  = cap_addr;
                    dm_wdata = cap_wdata;
                    if (dm_done) begin
                        wb_d.valid      = 1'b1;
                        wb_d.mem_to_reg = cap_mem_to_reg;
                        wb_d.reg_write  = cap_reg_write;
                        wb_d.halt       = cap_halt;
                        wb_d.write_reg  = cap_write_reg;
                        wb_d.alu_result = cap_addr;
                        wb_d.read_data  = cap_wr ? '0 : dm_rdata;
                    end else begin
                        stall_out   = !timeout;
                        load_bubble = 1'b1;
                    end
                end
                default: load_bubble = 1'b1;
            endcase
        end
    end

    // Request FSM, watchdog counter and capture of the in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= MS_IDLE;
            wait_cnt       <= '0;
            err            <= 1'b0;
            cap_addr       <= '0;
            cap_wdata      <= '0;
            cap_wr         <= 1'b0;
            cap_mem_to_reg <= 1'b0;
            cap_reg_write  <= 1'b0;
            cap_write_reg  <= '0;
            cap_halt       <= 1'b0;
        end else begin
            case (state)
                MS_IDLE: begin
                    if (is_mem_op && misaligned) begin
                        err <= 1'b1;
                    end else if (is_mem_op) begin
                        cap_addr       <= alu_result;
                        cap_wdata      <= store_data;
                        cap_wr         <= mem_write;
                        cap_mem_to_reg <= mem_to_reg;
                        cap_reg_write  <= reg_write;
                        cap_write_reg  <= write_reg;
                        cap_halt       <= halt;
                        wait_cnt       <= '0;
                        state          <= MS_BUSY;
                    end
                end
                MS_BUSY: begin
                    if (dm_done) begin
                        state <= MS_IDLE;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= MS_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .rst         (rst),
        .load_bubble (load_bubble),
        .d           (wb_d),
        .q           (wb_q)
    );

    assign wb_valid      = wb_q.valid;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_halt       = wb_q.halt;
    assign wb_write_reg  = wb_q.write_reg;
    assign wb_alu_result = wb_q.alu_result;
    assign wb_read_data  = wb_q.read_data;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short watchdog (MAX_WAIT=4); the bench
// plays the data memory by driving dm_done/dm_rdata cycle by cycle.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic        halt;
    logic        stall_out;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_done;
    logic [15:0] dm_rdata;
    logic        wb_valid;
    logic        wb_mem_to_reg;
    logic        wb_reg_write;
    logic        wb_halt;
    logic [2:0]  wb_write_reg;
    logic [15:0] wb_alu_result;
    logic [15:0] wb_read_data;
    logic        err;

    int compared = 0;
    int mismatched = 0;

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .write_reg     (write_reg),
        .halt          (halt),
        .stall_out     (stall_out),
        .dm_req        (dm_req),
        .dm_wr         (dm_wr),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_done       (dm_done),
        .dm_rdata      (dm_rdata),
        .wb_valid      (wb_valid),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_halt       (wb_halt),
        .wb_write_reg  (wb_write_reg),
        .wb_alu_result (wb_alu_result),
        .wb_read_data  (wb_read_data),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid   = 1'b0;
        alu_result = 16'h0000;
        store_data = 16'h0000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        write_reg  = 3'd0;
        halt       = 1'b0;
        dm_done    = 1'b0;
        dm_rdata   = 16'h0000;
    endtask

    task automatic set_op(input logic [15:0] addr, input logic [15:0] sdata, input logic rd,
                          input logic wr, input logic m2r, input logic rw, input logic [2:0] wreg);
        in_valid   = 1'b1;
        alu_result = addr;
        store_data = sdata;
        mem_read   = rd;
        mem_write  = wr;
        mem_to_reg = m2r;
        reg_write  = rw;
        write_reg  = wreg;
        halt       = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        set_idle();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        step();
        step();
        set_op(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        #1;
        if (dm_req !== 1'b0) begin $display("[TB] FAIL reset_dm_req: got %b want 0", dm_req); mismatched++; end
        compared++;
        if (stall_out !== 1'b0) begin $display("[TB] FAIL reset_stall: got %b want 0", stall_out); mismatched++; end
        compared++;
        if ({wb_valid, wb_reg_write, wb_halt, wb_mem_to_reg} !== 4'b0000) begin
            $display("[TB] FAIL reset_wb_ctrl: got %b want 0000", {wb_valid, wb_reg_write, wb_halt, wb_mem_to_reg}); mismatched++;
        end
        compared++;
        if ({wb_alu_result, wb_read_data, wb_write_reg} !== 35'd0) begin
            $display("[TB] FAIL reset_wb_data: got %h want 0", {wb_alu_result, wb_read_data, wb_write_reg}); mismatched++;
        end
        compared++;
        if (err !== 1'b0) begin $display("[TB] FAIL reset_err: got %b want 0", err); mismatched++; end
        compared++;
        set_idle();
        step();
        rst = 1'b0;
    endtask

    task automatic test_alu_pass();
        set_op(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
        #1;
        if (stall_out !== 1'b0 || dm_req !== 1'b0) begin
            $display("[TB] FAIL alu_no_stall: got stall=%b req=%b want 0/0", stall_out, dm_req); mismatched++;
        end
        compared++;
        step();
        if (wb_valid !== 1'b1) begin $display("[TB] FAIL alu_wb_valid: got %b want 1", wb_valid); mismatched++; end
        compared++;
        if (wb_alu_result !== 16'h1234) begin $display("[TB] FAIL alu_result: got %h want 1234", wb_alu_result); mismatched++; end
        compared++;
        if (wb_write_reg !== 3'd3 || wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b1) begin
            $display("[TB] FAIL alu_ctrl: got reg=%0d rw=%b m2r=%b want 3/1/1", wb_write_reg, wb_reg_write, wb_mem_to_reg); mismatched++;
        end
        compared++;
        set_idle();
    endtask

    task automatic test_load();
        set_op(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
        for (int i = 0; i < 4; i++) begin
            // done in the request cycle must be ignored; the real one comes 3 cycles later
            dm_done  = (i == 0) || (i == 3);
            dm_rdata = (i == 3) ? 16'hBEEF : 16'hDEAD;
            #1;
            if (stall_out !== (i < 3)) begin $display("[TB] FAIL load_stall_c%0d: got %b want %b", i, stall_out, i < 3); mismatched++; end
            compared++;
            if (dm_req !== 1'b1 || dm_wr !== 1'b0 || dm_addr !== 16'h0040) begin
                $display("[TB] FAIL load_req_c%0d: got req=%b wr=%b addr=%h want 1/0/0040", i, dm_req, dm_wr, dm_addr); mismatched++;
            end
            compared++;
            step();
            if (wb_valid !== (i == 3)) begin $display("[TB] FAIL load_wb_valid_c%0d: got %b want %b", i, wb_valid, i == 3); mismatched++; end
            compared++;
        end
        if (wb_read_data !== 16'hBEEF) begin $display("[TB] FAIL load_data: got %h want beef", wb_read_data); mismatched++; end
        compared++;
        if (wb_mem_to_reg !== 1'b0 || wb_reg_write !== 1'b1 || wb_write_reg !== 3'd5) begin
            $display("[TB] FAIL load_ctrl: got m2r=%b rw=%b reg=%0d want 0/1/5", wb_mem_to_reg, wb_reg_write, wb_write_reg); mismatched++;
        end
        compared++;
        set_idle();
        #1;
        if (dm_req !== 1'b0) begin $display("[TB] FAIL load_req_drop: got %b want 0", dm_req); mismatched++; end
        compared++;
        step();
        if (wb_valid !== 1'b0) begin $display("[TB] FAIL load_single_pulse: got %b want 0", wb_valid); mismatched++; end
        compared++;
    endtask

    task automatic test_store();
        set_op(16'h0010, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        #1;
        if (dm_req !== 1'b1 || dm_wr !== 1'b1 || dm_addr !== 16'h0010 || dm_wdata !== 16'h00FF || stall_out !== 1'b1) begin
            $display("[TB] FAIL store_issue: got req=%b wr=%b addr=%h wdata=%h stall=%b want 1/1/0010/00ff/1",
                     dm_req, dm_wr, dm_addr, dm_wdata, stall_out); mismatched++;
        end
        compared++;
        step();
        // Scramble the live inputs: the request must come from the captured copy.
        set_op(16'h0222, 16'hAAAA, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6);
        dm_done  = 1'b1;
        dm_rdata = 16'h5555;
        #1;
        if (dm_req !== 1'b1 || dm_wr !== 1'b1 || dm_addr !== 16'h0010 || dm_wdata !== 16'h00FF || stall_out !== 1'b0) begin
            $display("[TB] FAIL store_held: got req=%b wr=%b addr=%h wdata=%h stall=%b want 1/1/0010/00ff/0",
                     dm_req, dm_wr, dm_addr, dm_wdata, stall_out); mismatched++;
        end
        compared++;
        step();
        if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_read_data !== 16'h0000) begin
            $display("[TB] FAIL store_wb: got v=%b rw=%b rdata=%h want 1/0/0000", wb_valid, wb_reg_write, wb_read_data); mismatched++;
        end
        compared++;
        set_idle();
        step();
        if (wb_valid !== 1'b0) begin $display("[TB] FAIL store_single_pulse: got %b want 0", wb_valid); mismatched++; end
        compared++;
    endtask

    task automatic test_misaligned();
        set_op(16'h0041, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
        #1;
        if (dm_req !== 1'b0 || stall_out !== 1'b0) begin
            $display("[TB] FAIL misalign_req: got req=%b stall=%b want 0/0", dm_req, stall_out); mismatched++;
        end
        compared++;
        step();
        if (err !== 1'b1 || wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin
            $display("[TB] FAIL misalign_err: got err=%b v=%b rw=%b want 1/0/0", err, wb_valid, wb_reg_write); mismatched++;
        end
        compared++;
        set_idle();
        step();
        step();
        if (err !== 1'b1) begin $display("[TB] FAIL misalign_sticky: got %b want 1", err); mismatched++; end
        compared++;
    endtask

    task automatic test_watchdog();
        pulse_reset();
        set_op(16'h0080, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
        // request cycle plus four BUSY cycles, the last of which times out
        for (int i = 0; i < 5; i++) begin
            #1;
            if (stall_out !== (i < 4) || dm_req !== 1'b1) begin
                $display("[TB] FAIL wd_c%0d: got stall=%b req=%b want %b/1", i, stall_out, dm_req, i < 4); mismatched++;
            end
            compared++;
            if (err !== 1'b0) begin $display("[TB] FAIL wd_err_early_c%0d: got %b want 0", i, err); mismatched++; end
            compared++;
            step();
        end
        set_idle();
        #1;
        if (err !== 1'b1 || dm_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b0) begin
            $display("[TB] FAIL wd_fault: got err=%b req=%b stall=%b v=%b want 1/0/0/0", err, dm_req, stall_out, wb_valid); mismatched++;
        end
        compared++;

        pulse_reset();
        set_op(16'h0090, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
        for (int i = 0; i < 5; i++) begin
            dm_done  = (i == 4);
            dm_rdata = 16'h1357;
            #1;
            if (stall_out !== (i < 4)) begin $display("[TB] FAIL wd_done_stall_c%0d: got %b want %b", i, stall_out, i < 4); mismatched++; end
            compared++;
            step();
        end
        set_idle();
        #1;
        if (err !== 1'b0 || wb_valid !== 1'b1 || wb_read_data !== 16'h1357) begin
            $display("[TB] FAIL wd_done_last: got err=%b v=%b rdata=%h want 0/1/1357", err, wb_valid, wb_read_data); mismatched++;
        end
        compared++;
        step();
    endtask

    task automatic test_reset_mid_access();
        set_op(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        if (dm_req !== 1'b0 || stall_out !== 1'b0) begin
            $display("[TB] FAIL midrst_forced: got req=%b stall=%b want 0/0", dm_req, stall_out); mismatched++;
        end
        compared++;
        step();
        rst = 1'b0;
        set_op(16'h0042, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7);
        #1;
        if (dm_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b0 || err !== 1'b0 || wb_alu_result !== 16'h0000) begin
            $display("[TB] FAIL midrst_state: got req=%b stall=%b v=%b err=%b alu=%h want 0/0/0/0/0000",
                     dm_req, stall_out, wb_valid, err, wb_alu_result); mismatched++;
        end
        compared++;
        step();
        if (wb_valid !== 1'b1 || wb_alu_result !== 16'h0042 || wb_write_reg !== 3'd7) begin
            $display("[TB] FAIL midrst_next_alu: got v=%b alu=%h reg=%0d want 1/0042/7", wb_valid, wb_alu_result, wb_write_reg); mismatched++;
        end
        compared++;
        set_idle();
        step();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        $display("[TB] starting mem_stage bench");
        test_reset();
        test_alu_pass();
        test_load();
        test_store();
        test_misaligned();
        test_watchdog();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 16-bit five-stage pipeline, between the EX/MEM latch and the write-back stage. Issues loads and stores to a multi-cycle data memory over a request/done handshake and stalls the upstream pipeline until the access completes. Owns the MEM/WB pipeline register that feeds write-back: ALU result, load data, the write-back mux select, and register-write controls.

## Interface
- `MAX_WAIT`, default 15: maximum cycles to wait for `dm_done` after a request before declaring a memory fault.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: EX/MEM holds a live instruction.
- `alu_result` input 16: ALU output, used as the memory address for loads and stores.
- `store_data` input 16: store data.
- `mem_read`, `mem_write` input 1 each: load or store; never both high.
- `mem_to_reg` input 1: write-back select; 0 selects load data, 1 selects ALU result.
- `reg_write` input 1, `write_reg` input 3, `halt` input 1: passed through to the MEM/WB register.
- `stall_out` output 1: hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `dm_req` output 1, `dm_wr` output 1, `dm_addr` output 16, `dm_wdata` output 16: data memory request.
- `dm_done` input 1, `dm_rdata` input 16: memory completion and read data.
- `wb_valid`, `wb_mem_to_reg`, `wb_reg_write`, `wb_halt` output 1 each; `wb_write_reg` output 3; `wb_alu_result`, `wb_read_data` output 16: MEM/WB register.
- `err` output 1: sticky fault flag.

## Operation
- **State machine:** two states, IDLE and BUSY.
- **Memory op:** `in_valid & (mem_read | mem_write)`.
- **IDLE, non-memory op or bubble:** no stall. The MEM/WB register loads all inputs at the next edge. `wb_read_data` loads 0.
- **IDLE, aligned memory op** (`alu_result[0]==0`):
  - Drive `dm_req=1`, `dm_wr=mem_write`, `dm_addr=alu_result`, `dm_wdata=store_data` combinationally.
  - Assert `stall_out`.
  - Capture address, data and all controls into internal registers, then go to BUSY.
  - MEM/WB loads a bubble at that edge.
- **BUSY:**
  - Keep `dm_req` high, driven from the captured registers.
  - Each cycle without `dm_done`: `stall_out=1`, MEM/WB loads a bubble, wait counter increments.
  - Cycle with `dm_done`: `stall_out=0` and `dm_req` stays high that cycle. At the edge, MEM/WB loads the captured controls, with `wb_read_data=dm_rdata` (stores load 0). Then return to IDLE.
- **Bubble:** `wb_valid=0`, `wb_reg_write=0`, `wb_halt=0`; the other MEM/WB fields are don't-care.
- **Misaligned memory op** (`alu_result[0]==1`): no `dm_req`, no stall. `err` sets at the next edge. The instruction is dropped: MEM/WB loads a bubble.
- **Watchdog:** the counter clears on entering BUSY. If it reaches `MAX_WAIT` without `dm_done`:
  - Set `err`, deassert `dm_req`, drop the instruction (bubble), return to IDLE.
  - `stall_out=0` in that cycle.
- **`err`:** once set, held until `rst`.

## Timing
- **Reset:** state IDLE, counter 0, `err=0`, all MEM/WB outputs 0.
  - While `rst` is high, `dm_req` and `stall_out` are forced to 0.
  - Reset in BUSY abandons the access; the memory must tolerate a dropped request.
- **Latency, non-memory op:** 1 cycle, EX/MEM to MEM/WB.
- **Latency, memory op:** request in cycle N, `dm_done` no earlier than N+1. Result is in MEM/WB after the edge ending the `dm_done` cycle.
  - A `dm_done` in the IDLE request cycle is ignored.
- **Stall length:** one cycle plus one per BUSY cycle without `dm_done`. Upstream advances on the same edge that loads the result, so there is no duplicate and no lost instruction.
- **Simultaneous events:** `dm_done` in the cycle the counter hits `MAX_WAIT` counts as completion, not a fault.
- **Counter width:** `$clog2(MAX_WAIT+1)` bits; it never wraps.

## Structure
- A shared pipeline package holds:
  - the state encoding (`MS_IDLE`, `MS_BUSY`);
  - the 16-bit word width constant;
  - the write-back select encoding (`WB_SEL_MEM=0`, `WB_SEL_ALU=1`).
- One sub-module, `mem_wb_reg`: the MEM/WB register with a load-bubble input, built from the codebase's synchronous-reset flops.
- FSM, watchdog and request capture stay in `mem_stage`.

## Test plan
- **Add pass-through:** ALU op (`alu_result=0x1234`, `reg_write=1`, `write_reg=3`, `mem_to_reg=1`) → next cycle `wb_valid=1`, `wb_alu_result=0x1234`, `wb_write_reg=3`, `stall_out` never high.
- **Load:** load at 0x0040, `dm_done` three cycles after request with `dm_rdata=0xBEEF`:
  - `stall_out` high for 3 cycles;
  - MEM/WB bubbles for 3 cycles, then `wb_read_data=0xBEEF`, `wb_mem_to_reg=0`, exactly one `wb_valid` pulse.
- **Store:** store `0x00FF` to 0x0010, `dm_done` one cycle after request → `dm_wr=1`, `dm_addr=0x0010`, `dm_wdata=0x00FF` held until done; then one MEM/WB entry with `wb_reg_write=0`.
- **Misaligned load:** load at 0x0041 → no `dm_req`, no stall, `err=1` next cycle and stays 1, MEM/WB bubble.
- **Watchdog:** `MAX_WAIT=4`, `dm_done` never asserted → `err` set after 4 BUSY cycles, `dm_req` drops, `stall_out` released. Repeat with `dm_done` on the 4th cycle → normal completion, `err=0`.
- **Reset mid-access:** `rst` asserted in the second BUSY cycle → IDLE, `dm_req=0`, all outputs 0 after the edge. A following ALU op passes normally.
